// File: rtl/memory_controller_if.sv
// rtl/memory_controller_if.sv - core/RAM bus bundle for the memory controller
interface memory_controller_if #(
  parameter int DATA_WIDTH = 32
);
  // Core side
  logic [DATA_WIDTH-1:0] addressIn;
  logic [DATA_WIDTH-1:0] dataWriteIn;
  logic [1:0]            length;
  logic                  storeIn;
  logic                  loadIn;
  logic                  loadUnsigned;
  logic [DATA_WIDTH-1:0] dataReadOut;
  // RAM side
  logic [DATA_WIDTH-1:0] ramDataRead;
  logic [DATA_WIDTH-1:0] addressOut;
  logic [DATA_WIDTH-1:0] ramDataWrite;
  logic [3:0]            byteSelect;
  logic                  ramStore;
  logic                  ramLoad;

  modport slave (
    input  addressIn, dataWriteIn, length, storeIn, loadIn, loadUnsigned, ramDataRead,
    output dataReadOut, addressOut, ramDataWrite, byteSelect, ramStore, ramLoad
  );

  modport master (
    output addressIn, dataWriteIn, length, storeIn, loadIn, loadUnsigned, ramDataRead,
    input  dataReadOut, addressOut, ramDataWrite, byteSelect, ramStore, ramLoad
  );
endinterface

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte/half/word lane steering between core and word RAM
module memory_controller #(
  parameter int DATA_WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  memory_controller_if.slave bus
);

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  logic [1:0]            off;
  logic [1:0]            off_q, off_d;
  logic [1:0]            len_q, len_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] rd_shifted;

  // Byte offset of the access inside the word; misaligned halves/words are truncated
  always_comb begin
    off = 2'b00;
    case (bus.length)
      LEN_BYTE: off = bus.addressIn[1:0];
      LEN_HALF: off = {bus.addressIn[1], 1'b0};
      default:  off = 2'b00;
    endcase
  end

  assign bus.addressOut   = {bus.addressIn[DATA_WIDTH-1:2], 2'b00};
  assign bus.ramStore     = bus.storeIn;
  assign bus.ramLoad      = bus.loadIn;
  assign bus.ramDataWrite = bus.dataWriteIn << {off, 3'b000};

  // Per-byte write enables; silent when no store is requested
  always_comb begin
    bus.byteSelect = 4'b0000;
    if (bus.storeIn) begin
      case (bus.length)
        LEN_BYTE: bus.byteSelect = 4'b0001 << off;
        LEN_HALF: bus.byteSelect = 4'b0011 << off;
        default:  bus.byteSelect = 4'b1111;
      endcase
    end
  end

  // Load context is captured with the request and held until the next load
  always_comb begin
    off_d = off_q;
    len_d = len_q;
    uns_d = uns_q;
    if (bus.loadIn) begin
      off_d = off;
      len_d = bus.length;
      uns_d = bus.loadUnsigned;
    end
  end

  // Context register; reset value makes the read path a plain word pass-through
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_q <= 2'b00;
      len_q <= LEN_WORD;
      uns_q <= 1'b0;
    end else begin
      off_q <= off_d;
      len_q <= len_d;
      uns_q <= uns_d;
    end
  end

  assign rd_shifted = bus.ramDataRead >> {off_q, 3'b000};

  // Extract and extend the addressed lane from the RAM's registered read word
  always_comb begin
    bus.dataReadOut = bus.ramDataRead;
    case (len_q)
      LEN_BYTE: bus.dataReadOut = {{(DATA_WIDTH-8){~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
      LEN_HALF: bus.dataReadOut = {{(DATA_WIDTH-16){~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default:  bus.dataReadOut = bus.ramDataRead;
    endcase
  end

endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - scoreboard bench for memory_controller
module tb_memory_controller;

  localparam int SIG_ADDR = 0;
  localparam int SIG_WDAT = 1;
  localparam int SIG_BSEL = 2;
  localparam int SIG_STR  = 3;
  localparam int SIG_LDS  = 4;
  localparam int SIG_RDAT = 5;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  memory_controller_if #(.DATA_WIDTH(32)) bus ();

  memory_controller #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] get_sig(input int sig);
    case (sig)
      SIG_ADDR: return bus.addressOut;
      SIG_WDAT: return bus.ramDataWrite;
      SIG_BSEL: return {28'h0, bus.byteSelect};
      SIG_STR:  return {31'h0, bus.ramStore};
      SIG_LDS:  return {31'h0, bus.ramLoad};
      default:  return bus.dataReadOut;
    endcase
  endfunction

  task automatic expect_val(input string nm, input int sig, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sig = sig;
    e.exp = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] l,
                       input logic st, input logic ld, input logic us, input logic [31:0] rd);
    bus.addressIn    = a;
    bus.dataWriteIn  = d;
    bus.length       = l;
    bus.storeIn      = st;
    bus.loadIn       = ld;
    bus.loadUnsigned = us;
    bus.ramDataRead  = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: at each falling edge, pop every expectation due this cycle and compare
  initial begin
    exp_t        e;
    logic [31:0] act;
    n_checks = 0;
    n_pass   = 0;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (e.cyc < cyc) begin
          $display("FAIL %s: not sampled in its cycle, got none required %08h", e.nm, e.exp);
        end else begin
          act = get_sig(e.sig);
          if (act === e.exp) n_pass++;
          else $display("FAIL %s: got %08h required %08h", e.nm, act, e.exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0);

    // reset held: context is pass-through, combinational outputs still live
    step();
    drive(32'h13, 32'hAB, 2'b00, 1'b1, 1'b0, 1'b0, 32'hA5A51234);
    expect_val("rst_rdata", SIG_RDAT, 32'hA5A51234);
    expect_val("rst_bsel",  SIG_BSEL, 32'h8);
    expect_val("rst_store", SIG_STR,  32'h1);
    expect_val("rst_addr",  SIG_ADDR, 32'h10);

    // word store
    step();
    reset = 1'b0;
    drive(32'h10, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_val("sw_addr",  SIG_ADDR, 32'h10);
    expect_val("sw_bsel",  SIG_BSEL, 32'hF);
    expect_val("sw_wdata", SIG_WDAT, 32'hDEADBEEF);
    expect_val("sw_store", SIG_STR,  32'h1);
    expect_val("sw_load",  SIG_LDS,  32'h0);

    // byte store at lane 3
    step();
    drive(32'h13, 32'hAB, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_val("sb_bsel",  SIG_BSEL, 32'h8);
    expect_val("sb_wdata", SIG_WDAT, 32'hAB000000);
    expect_val("sb_addr",  SIG_ADDR, 32'h10);

    // halfword store, aligned then misaligned (truncated to same lanes)
    step();
    drive(32'h16, 32'h1234CDEF, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_val("sh_bsel",  SIG_BSEL, 32'hC);
    expect_val("sh_wdata", SIG_WDAT, 32'hCDEF0000);
    expect_val("sh_addr",  SIG_ADDR, 32'h14);
    step();
    drive(32'h17, 32'h1234CDEF, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_val("sh_mis_bsel",  SIG_BSEL, 32'hC);
    expect_val("sh_mis_wdata", SIG_WDAT, 32'hCDEF0000);

    // signed byte load request
    step();
    drive(32'h11, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_val("lb_load",  SIG_LDS,  32'h1);
    expect_val("lb_store", SIG_STR,  32'h0);
    expect_val("lb_bsel",  SIG_BSEL, 32'h0);
    expect_val("lb_addr",  SIG_ADDR, 32'h10);

    // data for signed byte; issue unsigned byte
    step();
    drive(32'h11, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h1234F678);
    expect_val("lb_signed", SIG_RDAT, 32'hFFFFFFF6);

    // data for unsigned byte; issue signed half at 0x22
    step();
    drive(32'h22, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0, 32'h1234F678);
    expect_val("lbu", SIG_RDAT, 32'h000000F6);

    // data for half; issue misaligned half at 0x23
    step();
    drive(32'h23, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0, 32'h8001FFFF);
    expect_val("lh_signed", SIG_RDAT, 32'hFFFF8001);

    // data for misaligned half; issue signed byte at 0x01
    step();
    drive(32'h01, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h8001FFFF);
    expect_val("lh_misaligned", SIG_RDAT, 32'hFFFF8001);

    // data for byte at 0x01; issue word at 0x04 back to back
    step();
    drive(32'h04, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h11223344);
    expect_val("b2b_byte", SIG_RDAT, 32'h00000033);

    // data for word; no further load
    step();
    drive(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h89ABCDEF);
    expect_val("b2b_word", SIG_RDAT, 32'h89ABCDEF);
    expect_val("idle_bsel", SIG_BSEL, 32'h0);

    // context holds while loadIn is low even if length changes
    step();
    drive(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h01020304);
    expect_val("hold_word", SIG_RDAT, 32'h01020304);

    // simultaneous store and load
    step();
    drive(32'h02, 32'h55, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0);
    expect_val("sl_store", SIG_STR,  32'h1);
    expect_val("sl_load",  SIG_LDS,  32'h1);
    expect_val("sl_bsel",  SIG_BSEL, 32'h4);
    expect_val("sl_wdata", SIG_WDAT, 32'h00550000);

    // data for the unsigned byte at lane 2; issue signed byte at lane 3
    step();
    drive(32'h03, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'hAABBCCDD);
    expect_val("sl_rdata", SIG_RDAT, 32'h000000BB);

    // reset lands between the request and its data cycle
    step();
    drive(32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h80123456);
    expect_val("rst_midload", SIG_RDAT, 32'h80123456);
    #1;
    reset = 1'b1;

    // first load after reset release
    step();
    reset = 1'b0;
    drive(32'h00, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'hFFFFFF80);
    expect_val("post_rst_word", SIG_RDAT, 32'hFFFFFF80);
    step();
    drive(32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h123456FE);
    expect_val("post_rst_byte", SIG_RDAT, 32'hFFFFFFFE);

    step();
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s: never compared, got none required %08h", e.nm, e.exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
